// File: rtl/axis_linear_pars_pingpong_buf.sv
`default_nettype none
// ============================================================================
// Module   : axis_linear_pars_pingpong_buf
// Brief    : Ping-pong buffer for linear parameter pairs (A, B). An AXI-Stream
//            loader fills the write bank one lane per cycle while a two-stage
//            read pipeline serves the read bank. Banks swap on request once
//            the write bank holds both A and B.
// Revision : 1.0 - initial release
// ============================================================================
module axis_linear_pars_pingpong_buf #(
  parameter int PAR_WIDTH    = 16,
  parameter int STREAM_WIDTH = 64,
  parameter int MAX_KERNAL_N = 512,
  parameter int A_DEFAULT    = 1,
  parameter int SIM_DELAY    = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [STREAM_WIDTH-1:0]   s_axis_data,
  input  logic [STREAM_WIDTH/8-1:0] s_axis_keep,
  input  logic                      s_axis_last,
  input  logic [1:0]                s_axis_user,
  input  logic                      s_axis_valid,
  output logic                      s_axis_ready,
  input  logic                      rst_wbank,
  input  logic                      bank_switch,
  output logic                      wbank_loaded,
  output logic                      rbank_ready,
  output logic                      bank_sel,
  input  logic                      rd_ren_s0,
  input  logic                      rd_ren_s1,
  input  logic [15:0]               rd_addr,
  output logic [PAR_WIDTH-1:0]      dout_a,
  output logic [PAR_WIDTH-1:0]      dout_b
);

  localparam int L   = STREAM_WIDTH / PAR_WIDTH;
  localparam int LW  = (L > 1) ? $clog2(L) : 1;
  localparam int RAW = (MAX_KERNAL_N > 1) ? $clog2(MAX_KERNAL_N) : 1;
  localparam int AW  = $clog2(MAX_KERNAL_N + 1);
  localparam int KB  = PAR_WIDTH / 8;

  localparam logic [LW-1:0]        LANE_LAST   = LW'(L - 1);
  localparam logic [AW-1:0]        WADDR_MAX   = AW'(MAX_KERNAL_N);
  localparam logic [15:0]          RADDR_MAX   = 16'(MAX_KERNAL_N);
  localparam logic [PAR_WIDTH-1:0] A_DEF_VALUE = PAR_WIDTH'(A_DEFAULT);

  // Register updates are zero-delay here; SIM_DELAY is accepted only so the
  // block stays a drop-in replacement for existing instantiations.
  localparam int SIM_DELAY_UNUSED = SIM_DELAY;

  // Parameter storage: [bank][kernel index]
  logic [PAR_WIDTH-1:0] ram_a [2][MAX_KERNAL_N];
  logic [PAR_WIDTH-1:0] ram_b [2][MAX_KERNAL_N];

  // Bank / load-state registers (one flag per bank)
  logic          bank_sel_q, bank_sel_d;
  logic [1:0]    loaded_a_q, loaded_a_d;
  logic [1:0]    loaded_b_q, loaded_b_d;
  logic [1:0]    vld_a_q,    vld_a_d;
  logic [1:0]    vld_b_q,    vld_b_d;
  logic [LW-1:0] lane_q,     lane_d;
  logic [AW-1:0] waddr_q,    waddr_d;

  // Read pipeline registers
  logic [PAR_WIDTH-1:0] ram_a_rd_q, ram_a_rd_d;
  logic [PAR_WIDTH-1:0] ram_b_rd_q, ram_b_rd_d;
  logic                 s0_vld_a_q, s0_vld_a_d;
  logic                 s0_vld_b_q, s0_vld_b_d;
  logic                 s0_in_range_q, s0_in_range_d;
  logic [PAR_WIDTH-1:0] dout_a_q, dout_a_d;
  logic [PAR_WIDTH-1:0] dout_b_q, dout_b_d;

  // Combinational helpers
  logic                 wbank;
  logic                 rbank;
  logic                 beat_done;
  logic                 switch_ok;
  logic                 wr_en;
  logic [RAW-1:0]       wr_idx;
  logic [RAW-1:0]       rd_idx;
  logic [PAR_WIDTH-1:0] lane_data [L];
  logic [L-1:0]         lane_keep;
  logic                 keep_unused;

  // Only the first keep bit of each lane qualifies the write; the rest are
  // folded here so they are visibly consumed.
  assign keep_unused = ^s_axis_keep;

  // Split the beat into per-lane parameters and per-lane keep qualifiers
  for (genvar g = 0; g < L; g++) begin : g_lane
    assign lane_data[g] = s_axis_data[g*PAR_WIDTH +: PAR_WIDTH];
    assign lane_keep[g] = s_axis_keep[g*KB];
  end

  assign wbank        = bank_sel_q;
  assign rbank        = ~bank_sel_q;
  assign s_axis_ready = (lane_q == LANE_LAST);
  assign beat_done    = s_axis_valid & s_axis_ready & s_axis_last;
  assign wbank_loaded = loaded_a_q[wbank] & loaded_b_q[wbank];
  assign rbank_ready  = loaded_a_q[rbank] & loaded_b_q[rbank];
  assign switch_ok    = bank_switch & wbank_loaded;
  assign wr_idx       = waddr_q[RAW-1:0];
  assign rd_idx       = rd_addr[RAW-1:0];
  assign wr_en        = s_axis_valid & ~rst_wbank & lane_keep[lane_q] &
                        (waddr_q < WADDR_MAX);

  assign bank_sel = bank_sel_q;
  assign dout_a   = dout_a_q;
  assign dout_b   = dout_b_q;

  // Next-state for lane/address counters, bank select and per-bank flags
  always_comb begin
    bank_sel_d = bank_sel_q;
    loaded_a_d = loaded_a_q;
    loaded_b_d = loaded_b_q;
    vld_a_d    = vld_a_q;
    vld_b_d    = vld_b_q;
    lane_d     = lane_q;
    waddr_d    = waddr_q;

    if (rst_wbank) begin
      // Write-bank reset wins over any beat or switch in the same cycle
      loaded_a_d[wbank] = 1'b0;
      loaded_b_d[wbank] = 1'b0;
      vld_a_d[wbank]    = 1'b0;
      vld_b_d[wbank]    = 1'b0;
      lane_d            = '0;
      waddr_d           = '0;
    end else begin
      if (s_axis_valid) begin
        lane_d  = (lane_q == LANE_LAST) ? '0 : lane_q + 1'b1;
        waddr_d = (waddr_q < WADDR_MAX) ? waddr_q + 1'b1 : waddr_q;
        if (beat_done) begin
          waddr_d = '0;
          // Flags land in the pre-switch write bank even if a switch fires now
          if (s_axis_user[0]) begin
            loaded_b_d[wbank] = 1'b1;
            vld_b_d[wbank]    = s_axis_user[1];
          end else begin
            loaded_a_d[wbank] = 1'b1;
            vld_a_d[wbank]    = s_axis_user[1];
          end
        end
      end
      if (switch_ok) begin
        // The old read bank becomes the new write bank and starts empty
        bank_sel_d        = ~bank_sel_q;
        loaded_a_d[rbank] = 1'b0;
        loaded_b_d[rbank] = 1'b0;
        vld_a_d[rbank]    = 1'b0;
        vld_b_d[rbank]    = 1'b0;
        lane_d            = '0;
        waddr_d           = '0;
      end
    end
  end

  // Control state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank_sel_q <= 1'b0;
      loaded_a_q <= '0;
      loaded_b_q <= '0;
      vld_a_q    <= '0;
      vld_b_q    <= '0;
      lane_q     <= '0;
      waddr_q    <= '0;
    end else begin
      bank_sel_q <= bank_sel_d;
      loaded_a_q <= loaded_a_d;
      loaded_b_q <= loaded_b_d;
      vld_a_q    <= vld_a_d;
      vld_b_q    <= vld_b_d;
      lane_q     <= lane_d;
      waddr_q    <= waddr_d;
    end
  end

  // Parameter RAM write port (write bank only; never collides with reads)
  always_ff @(posedge clk) begin
    if (wr_en) begin
      if (s_axis_user[0]) begin
        ram_b[wbank][wr_idx] <= lane_data[lane_q];
      end else begin
        ram_a[wbank][wr_idx] <= lane_data[lane_q];
      end
    end
  end

  // Read pipeline next-state: stage 0 samples the read bank, stage 1 masks
  always_comb begin
    ram_a_rd_d    = ram_a_rd_q;
    ram_b_rd_d    = ram_b_rd_q;
    s0_vld_a_d    = s0_vld_a_q;
    s0_vld_b_d    = s0_vld_b_q;
    s0_in_range_d = s0_in_range_q;
    dout_a_d      = dout_a_q;
    dout_b_d      = dout_b_q;

    if (rd_ren_s0) begin
      ram_a_rd_d    = ram_a[rbank][rd_idx];
      ram_b_rd_d    = ram_b[rbank][rd_idx];
      s0_vld_a_d    = vld_a_q[rbank];
      s0_vld_b_d    = vld_b_q[rbank];
      s0_in_range_d = (rd_addr < RADDR_MAX);
    end
    // Stage 1 uses only stage-0 copies, so a switch in between is harmless
    if (rd_ren_s1) begin
      dout_a_d = (s0_vld_a_q & s0_in_range_q) ? ram_a_rd_q : A_DEF_VALUE;
      dout_b_d = (s0_vld_b_q & s0_in_range_q) ? ram_b_rd_q : '0;
    end
  end

  // Read pipeline registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ram_a_rd_q    <= '0;
      ram_b_rd_q    <= '0;
      s0_vld_a_q    <= 1'b0;
      s0_vld_b_q    <= 1'b0;
      s0_in_range_q <= 1'b0;
      dout_a_q      <= '0;
      dout_b_q      <= '0;
    end else begin
      ram_a_rd_q    <= ram_a_rd_d;
      ram_b_rd_q    <= ram_b_rd_d;
      s0_vld_a_q    <= s0_vld_a_d;
      s0_vld_b_q    <= s0_vld_b_d;
      s0_in_range_q <= s0_in_range_d;
      dout_a_q      <= dout_a_d;
      dout_b_q      <= dout_b_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_axis_linear_pars_pingpong_buf.sv
`default_nettype none
// ============================================================================
// Module   : tb_axis_linear_pars_pingpong_buf
// Brief    : Directed self-checking bench with a read scoreboard. Instance 0
//            uses 16-bit parameters on a 64-bit stream, instance 1 uses
//            32-bit parameters on a 128-bit stream.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axis_linear_pars_pingpong_buf;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Instance 0 (PAR_WIDTH=16, STREAM_WIDTH=64)
  logic [63:0] d0_data;
  logic [7:0]  d0_keep;
  logic        d0_last, d0_valid, d0_ready;
  logic [1:0]  d0_user;
  logic        d0_rst_wbank, d0_switch, d0_wloaded, d0_rready, d0_bsel;
  logic        d0_ren0, d0_ren1;
  logic [15:0] d0_raddr;
  logic [15:0] d0_da, d0_db;

  // Instance 1 (PAR_WIDTH=32, STREAM_WIDTH=128)
  logic [127:0] d1_data;
  logic [15:0]  d1_keep;
  logic         d1_last, d1_valid, d1_ready;
  logic [1:0]   d1_user;
  logic         d1_rst_wbank, d1_switch, d1_wloaded, d1_rready, d1_bsel;
  logic         d1_ren0, d1_ren1;
  logic [15:0]  d1_raddr;
  logic [31:0]  d1_da, d1_db;

  axis_linear_pars_pingpong_buf #(
    .PAR_WIDTH(16), .STREAM_WIDTH(64), .MAX_KERNAL_N(512), .A_DEFAULT(1), .SIM_DELAY(1)
  ) u_dut0 (
    .clk(clk), .rst_n(rst_n),
    .s_axis_data(d0_data), .s_axis_keep(d0_keep), .s_axis_last(d0_last),
    .s_axis_user(d0_user), .s_axis_valid(d0_valid), .s_axis_ready(d0_ready),
    .rst_wbank(d0_rst_wbank), .bank_switch(d0_switch),
    .wbank_loaded(d0_wloaded), .rbank_ready(d0_rready), .bank_sel(d0_bsel),
    .rd_ren_s0(d0_ren0), .rd_ren_s1(d0_ren1), .rd_addr(d0_raddr),
    .dout_a(d0_da), .dout_b(d0_db)
  );

  axis_linear_pars_pingpong_buf #(
    .PAR_WIDTH(32), .STREAM_WIDTH(128), .MAX_KERNAL_N(512), .A_DEFAULT(1), .SIM_DELAY(1)
  ) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .s_axis_data(d1_data), .s_axis_keep(d1_keep), .s_axis_last(d1_last),
    .s_axis_user(d1_user), .s_axis_valid(d1_valid), .s_axis_ready(d1_ready),
    .rst_wbank(d1_rst_wbank), .bank_switch(d1_switch),
    .wbank_loaded(d1_wloaded), .rbank_ready(d1_rready), .bank_sel(d1_bsel),
    .rd_ren_s0(d1_ren0), .rd_ren_s1(d1_ren1), .rd_addr(d1_raddr),
    .dout_a(d1_da), .dout_b(d1_db)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
  } rd_exp_t;

  rd_exp_t sb_q[$];
  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One parameter set on instance 0: nbeats beats of 4 lanes, values base+i
  task automatic load0(input logic [1:0] user, input int base, input int nbeats,
                       input bit rst_on_last);
    for (int b = 0; b < nbeats; b++) begin
      @(negedge clk);
      for (int l = 0; l < 4; l++) d0_data[16*l +: 16] = 16'(base + 4*b + l);
      d0_keep  = 8'hFF;
      d0_user  = user;
      d0_last  = (b == nbeats - 1);
      d0_valid = 1'b1;
      for (int k = 1; k < 4; k++) begin
        @(negedge clk);
        if (rst_on_last && (b == nbeats - 1) && (k == 3)) d0_rst_wbank = 1'b1;
      end
    end
    @(negedge clk);
    d0_valid     = 1'b0;
    d0_last      = 1'b0;
    d0_rst_wbank = 1'b0;
  endtask

  // One parameter set on instance 1; keep of the final beat is selectable
  task automatic load1(input logic [1:0] user, input int base, input int nbeats,
                       input logic [15:0] last_keep, input bit chk);
    for (int b = 0; b < nbeats; b++) begin
      @(negedge clk);
      for (int l = 0; l < 4; l++) d1_data[32*l +: 32] = 32'(base + 4*b + l);
      d1_keep  = (b == nbeats - 1) ? last_keep : 16'hFFFF;
      d1_user  = user;
      d1_last  = (b == nbeats - 1);
      d1_valid = 1'b1;
      for (int k = 0; k < 4; k++) begin
        if (k > 0) @(negedge clk);
        if (chk) begin
          #1;
          check($sformatf("w_ready_b%0d_l%0d", b, k), 32'(d1_ready), 32'(k == 3));
        end
      end
    end
    @(negedge clk);
    d1_valid = 1'b0;
    d1_last  = 1'b0;
  endtask

  // Issue a read (optionally with a switch in the same cycle) and score it
  task automatic read0(input string tag, input int addr, input int ea, input int eb,
                       input bit sw);
    rd_exp_t e;
    @(negedge clk);
    d0_raddr  = 16'(addr);
    d0_switch = sw;
    e.a = 32'(ea);
    e.b = 32'(eb);
    sb_q.push_back(e);
    @(negedge clk);
    d0_switch = 1'b0;
    @(posedge clk);
    #1;
    check({tag, "_depth"}, 32'(sb_q.size()), 32'd1);
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check({tag, "_a"}, 32'(d0_da), e.a);
      check({tag, "_b"}, 32'(d0_db), e.b);
    end
  endtask

  task automatic read1(input string tag, input int addr, input int ea, input int eb);
    rd_exp_t e;
    @(negedge clk);
    d1_raddr = 16'(addr);
    e.a = 32'(ea);
    e.b = 32'(eb);
    sb_q.push_back(e);
    @(posedge clk);
    @(posedge clk);
    #1;
    check({tag, "_depth"}, 32'(sb_q.size()), 32'd1);
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check({tag, "_a"}, d1_da, e.a);
      check({tag, "_b"}, d1_db, e.b);
    end
  endtask

  task automatic switch0();
    @(negedge clk);
    d0_switch = 1'b1;
    @(negedge clk);
    d0_switch = 1'b0;
    #1;
  endtask

  task automatic switch1();
    @(negedge clk);
    d1_switch = 1'b1;
    @(negedge clk);
    d1_switch = 1'b0;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    d0_data = '0; d0_keep = '0; d0_last = 0; d0_user = '0; d0_valid = 0;
    d0_rst_wbank = 0; d0_switch = 0; d0_ren0 = 1; d0_ren1 = 1; d0_raddr = '0;
    d1_data = '0; d1_keep = '0; d1_last = 0; d1_user = '0; d1_valid = 0;
    d1_rst_wbank = 0; d1_switch = 0; d1_ren0 = 1; d1_ren1 = 1; d1_raddr = '0;
    repeat (3) @(negedge clk);
    #1;
    // Reset state
    check("rst_bank_sel", 32'(d0_bsel), 0);
    check("rst_wloaded", 32'(d0_wloaded), 0);
    check("rst_rready", 32'(d0_rready), 0);
    check("rst_dout_a", 32'(d0_da), 0);
    check("rst_dout_b", 32'(d0_db), 0);
    check("rst_ready", 32'(d0_ready), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic load and read
    load0(2'b10, 1, 2, 1'b0);
    check("basic_wloaded_a_only", 32'(d0_wloaded), 0);
    load0(2'b11, 11, 2, 1'b0);
    check("basic_wloaded", 32'(d0_wloaded), 1);
    check("basic_rready_pre", 32'(d0_rready), 0);
    switch0();
    check("basic_bank_sel", 32'(d0_bsel), 1);
    check("basic_rready", 32'(d0_rready), 1);
    check("basic_wloaded_new", 32'(d0_wloaded), 0);
    read0("basic_r5", 5, 6, 16, 1'b0);
    read0("basic_r0", 0, 1, 11, 1'b0);
    read0("basic_r7", 7, 8, 18, 1'b0);

    // Invalid A defaults and out-of-range reads
    load0(2'b00, 21, 1, 1'b0);
    load0(2'b11, 31, 1, 1'b0);
    switch0();
    check("inv_bank_sel", 32'(d0_bsel), 0);
    read0("inv_r0", 0, 1, 31, 1'b0);
    read0("inv_r3", 3, 1, 34, 1'b0);
    read0("inv_r512", 512, 1, 0, 1'b0);
    read0("inv_r600", 600, 1, 0, 1'b0);

    // Premature switch and write-bank reset
    load0(2'b10, 41, 1, 1'b0);
    switch0();
    check("prem_bank_sel", 32'(d0_bsel), 0);
    check("prem_wloaded", 32'(d0_wloaded), 0);
    load0(2'b11, 51, 1, 1'b1);
    check("rstw_wloaded", 32'(d0_wloaded), 0);
    check("rstw_rready", 32'(d0_rready), 1);
    switch0();
    check("rstw_bank_sel", 32'(d0_bsel), 0);
    read0("rstw_r3", 3, 1, 34, 1'b0);

    // Ping-pong overlap: keep reading the old bank while loading the other
    fork
      begin
        load0(2'b10, 100, 1, 1'b0);
        load0(2'b11, 200, 1, 1'b0);
      end
      begin
        repeat (4) read0("pp_old", 2, 1, 33, 1'b0);
      end
    join
    check("pp_wloaded", 32'(d0_wloaded), 1);
    read0("pp_inflight", 2, 1, 33, 1'b1);
    check("pp_bank_sel", 32'(d0_bsel), 1);
    read0("pp_new_r2", 2, 102, 202, 1'b0);
    read0("pp_new_r0", 0, 100, 200, 1'b0);

    // Wide stream with partial keep on the final beat
    load1(2'b10, 7000, 2, 16'hFFFF, 1'b1);
    load1(2'b10, 1000, 2, 16'h00FF, 1'b0);
    load1(2'b11, 2000, 2, 16'hFFFF, 1'b0);
    check("wide_wloaded", 32'(d1_wloaded), 1);
    switch1();
    check("wide_bank_sel", 32'(d1_bsel), 1);
    read1("wide_r5", 5, 1005, 2005);
    read1("wide_r6", 6, 7006, 2006);
    read1("wide_r7", 7, 7007, 2007);
    read1("wide_r1", 1, 1001, 2001);

    // Reset in the middle of a beat, then a fresh load
    @(negedge clk);
    d0_data = 64'h0004_0003_0002_0001; d0_keep = 8'hFF; d0_user = 2'b10;
    d0_last = 1'b0; d0_valid = 1'b1;
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_bank_sel", 32'(d0_bsel), 0);
    check("mid_wloaded", 32'(d0_wloaded), 0);
    check("mid_rready", 32'(d0_rready), 0);
    check("mid_dout_a", 32'(d0_da), 0);
    check("mid_dout_b", 32'(d0_db), 0);
    check("mid_ready", 32'(d0_ready), 0);
    @(negedge clk);
    d0_valid = 1'b0;
    rst_n = 1'b1;
    load0(2'b10, 61, 1, 1'b0);
    load0(2'b11, 71, 1, 1'b0);
    switch0();
    check("fresh_bank_sel", 32'(d0_bsel), 1);
    check("fresh_rready", 32'(d0_rready), 1);
    read0("fresh_r3", 3, 64, 74, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
